// File: rtl/rx_uart_fifo.sv
// Asynchronous serial receiver with configurable framing and a receive FIFO.
// Each queued word carries its own framing and parity error flags.
module rx_uart_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [15:0]                     baud_div,
    input  logic                            rx_pin,
    input  logic                            rx_read,
    input  logic                            err_clr,
    output logic                            rx_done,
    output logic [DATA_BITS-1:0]            rx_byte,
    output logic                            rx_frame_err,
    output logic                            rx_parity_err,
    output logic [$clog2(FIFO_DEPTH):0]     rx_count,
    output logic                            rx_overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = DATA_BITS + 2;

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_WAITH = 3'd5;

    logic                 sync1_q, rxs_q, rxs_prev_q;
    logic [2:0]           state_q, state_d;
    logic [15:0]          div_q, div_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 fe;
    logic                 push;
    logic                 fall;
    logic                 expire;

    logic [WW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 ovr_q;
    logic                 pop, push_ok, ovr_set;
    logic [WW-1:0]        head;

    assign fall   = rxs_prev_q & ~rxs_q;
    assign expire = (cnt_q == 16'd1);

    // Two-flop synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rx_pin;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // Receive FSM next-state: bit timing, shifting and flag accumulation
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = (cnt_q != 16'd0) ? cnt_q - 16'd1 : 16'd0;
        bit_d   = bit_q;
        sh_d    = sh_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        fe      = ferr_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    div_d   = baud_div;
                    cnt_d   = baud_div >> 1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (expire) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = div_q;
                        bit_d   = 4'd0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    sh_d  = {rxs_q, sh_q[DATA_BITS-1:1]};
                    cnt_d = div_q;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PAR: begin
                if (expire) begin
                    perr_d  = ((^sh_q) ^ rxs_q) != ODD;
                    cnt_d   = div_q;
                    bit_d   = 4'd0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (expire) begin
                    fe     = ferr_q | ~rxs_q;
                    ferr_d = fe;
                    if (bit_q == LAST_STOP) begin
                        push    = 1'b1;
                        state_d = fe ? S_WAITH : S_IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        cnt_d = div_q;
                    end
                end
            end
            S_WAITH: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receive FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= 16'd0;
            cnt_q   <= 16'd0;
            bit_q   <= 4'd0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign pop     = rx_read & (count_q != '0);
    assign push_ok = push & ((count_q < DEPTH_C) | pop);
    assign ovr_set = push & ~push_ok;

    // FIFO storage; contents are only visible while the count covers them
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {fe, perr_q, sh_q};
        end
    end

    // FIFO pointers, occupancy and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (err_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign head          = rx_done ? mem_q[rd_ptr_q] : '0;
    assign rx_done       = (count_q != '0);
    assign rx_byte       = head[DATA_BITS-1:0];
    assign rx_parity_err = head[DATA_BITS];
    assign rx_frame_err  = head[DATA_BITS+1];
    assign rx_count      = count_q;
    assign rx_overrun    = ovr_q;

endmodule

// File: doc/rx_uart_fifo.md
# rx_uart_fifo

Parametrised successor to `rx_uart`: an asynchronous serial receiver with configurable data width, optional parity, one or two stop bits and a receive FIFO. It runs beside `tx_uart` on the same `baud_div` programming model, with `baud_div` in clocks per bit, e.g. 434 gives 115200 baud at 50 MHz. Each received word is queued with per-word framing and parity error flags, so bursts no longer depend on software reading every byte before the next frame ends.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9, sent LSB first.
- `PARITY_EN`, default 0: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 1 selects odd parity, 0 selects even. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits checked, 1 or 2.
- `FIFO_DEPTH`, default 16: FIFO depth in words, a power of two, at least 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud_div`  in  16  clocks per bit. Legal values are 4 or more. Latched at each start-bit detection.
- `rx_pin`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_read`  in  1  pop strobe, one word per cycle while asserted.
- `err_clr`  in  1  clears `rx_overrun`.
- `rx_done`  out  1  FIFO not empty.
- `rx_byte`  out  `DATA_BITS`  head-of-FIFO data, first-word-fall-through.
- `rx_frame_err`  out  1  framing error flag of the head word.
- `rx_parity_err`  out  1  parity error flag of the head word. Always 0 when `PARITY_EN`=0.
- `rx_count`  out  `$clog2(FIFO_DEPTH)+1`  number of words in the FIFO.
- `rx_overrun`  out  1  sticky flag: a word was dropped because the FIFO was full.

## Operation
- **Input synchroniser.** `rx_pin` passes through a 2-flop synchroniser with both flops reset to 1. All logic uses the synchronised signal `rxs`.
- **States:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE.**
  - A falling edge on `rxs` latches `baud_div` into `div_q`.
  - The bit timer is loaded with `div_q>>1`, then the FSM goes to START.
- **START.** When the timer expires, `rxs` is sampled.
  - Sample 1: glitch. Return to IDLE; nothing is pushed.
  - Sample 0: reload the timer with `div_q` and go to DATA.
- **DATA.** Sample `DATA_BITS` bits, one per `div_q` interval, shifting LSB first. Then go to PARITY if enabled, otherwise STOP.
- **PARITY.** Sample one bit. The parity error flag is set when the XOR of the data and parity bits does not equal `PARITY_ODD`.
- **STOP.** Sample `STOP_BITS` bits. The frame error flag is set if any sampled stop bit is 0.
- **Push.** On the final stop sample, the word and its flags are pushed (see the FIFO rules).
  - If every stop bit was 1, go to IDLE. The FSM is back in IDLE at mid-stop-bit, so it can resynchronise to a back-to-back start bit.
  - If any stop bit was 0, go to WAIT_HIGH.
- **WAIT_HIGH.** Stay until `rxs` is 1, then go to IDLE. This prevents a break condition from retriggering reception.
- **FIFO rules.**
  - A push is accepted when `rx_count < FIFO_DEPTH`, or when `rx_read` pops in the same cycle.
  - Otherwise the word is discarded and `rx_overrun` is set.
  - `rx_read` while the FIFO is empty is ignored.
  - A push and a pop in the same cycle leave `rx_count` unchanged.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Overrun flag.** `rx_overrun` is cleared by `err_clr`. If `err_clr` and a new overrun occur in the same cycle, set wins.
- **Word-level behaviour.** Words with error flags are queued like any other word; software decides what to do with them. With `DATA_BITS`<9 the upper bits are absent, not zero-padded.

## Timing
- **Reset values.** While `rst_n`=0, all outputs are 0: `rx_done`, `rx_byte`, both head flags, `rx_count`, `rx_overrun`. The FSM is in IDLE, the FIFO is empty and the synchroniser holds 1.
- **Reset mid-frame.** The partial frame and all FIFO contents are discarded.
- **Detection latency.** A line falling edge is detected 2–3 clocks after it occurs (synchroniser delay). Call the detection cycle T.
- **Sample instants.**
  - Start bit: T+`div_q>>1`.
  - Data bit k (0-based): T+`div_q>>1`+(k+1)·`div_q`.
  - Parity and stop bits follow at further `div_q` intervals.
- **Push latency.** A push happens on the final stop-sample edge. `rx_done`, `rx_byte` and `rx_count` update on that edge, and the new values are visible in the next cycle.
- **Pop timing.** `rx_read` sampled high on edge E with the FIFO non-empty pops the word. The next word, or `rx_done`=0, is visible after E.
- **Clock tolerance.** The receiver tolerates ±2% total baud mismatch at `baud_div`≥16.
- **Runtime `baud_div` changes.** A change to `baud_div` mid-frame takes effect at the next start bit.

## Test plan
- **Loopback.** Configuration `DATA_BITS`=8, no parity, `baud_div`=434, looped from `tx_uart`. Send 0xFF^i for i=0..255 → each word is read back exactly, with both error flags 0.
- **Back-to-back burst.** Send 16 frames with no read, then pop all 16 → `rx_count` goes 1..16, data comes out in order, `rx_overrun`=0. A 17th frame → the word is dropped, `rx_overrun`=1, FIFO contents are unchanged, and `err_clr` → `rx_overrun`=0.
- **Parity.** Configuration `PARITY_EN`=1, `PARITY_ODD`=1, `DATA_BITS`=7. Send 0x55 with the correct parity bit → `rx_parity_err`=0. Send it with the parity bit inverted → `rx_parity_err`=1 and `rx_byte`=0x55.
- **Framing.** Drive the stop bit low, then hold the line low for 3 bit times → one word is queued with `rx_frame_err`=1 and no further words appear until the line returns high. A following 0xA5 frame is received cleanly.
- **Glitch rejection.** A low pulse of `baud_div>>2` clocks → no push and `rx_count` stays 0. A pulse of a full bit time followed by high → one word 0xFF is queued with `rx_frame_err`=0.
- **Edge cases.** A full FIFO with `rx_read` on the same cycle as a push → the push is accepted and the count stays `FIFO_DEPTH`. `rst_n` pulsed low mid-DATA → all outputs read 0, and the next clean frame 0x3C is received correctly.
